// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types and default widths for the register-file write-port controller.
// The default widths must track the register file itself.
package regfile_wb_ctrl_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefAddWidth  = 3;
  localparam int unsigned DefNumReq    = 3;

  typedef enum logic [0:0] {
    StArb,
    StClear
  } state_e;

  // Round-robin pointer width, ceil(log2(num_req)), never below one bit
  function automatic int unsigned ptr_width(int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  localparam int unsigned DefPtrWidth = ptr_width(DefNumReq);

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Writeback request bus plus register-file write port.
// master = requesters/clear source, slave = controller.
interface regfile_wb_ctrl_if
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned AddWidth  = DefAddWidth,
  parameter int unsigned NumReq    = DefNumReq
) ();

  logic [NumReq-1:0]           REQ_VALID;
  logic [NumReq*AddWidth-1:0]  REQ_WADD;
  logic [NumReq*DataWidth-1:0] REQ_DATA;
  logic [NumReq-1:0]           REQ_READY;
  logic                        CLR_START;
  logic                        CLR_BUSY;
  logic                        WEN;
  logic [AddWidth-1:0]         WADD;
  logic [DataWidth-1:0]        DATAIN;

  modport master (
    output REQ_VALID, REQ_WADD, REQ_DATA, CLR_START,
    input  REQ_READY, CLR_BUSY, WEN, WADD, DATAIN
  );

  modport slave (
    input  REQ_VALID, REQ_WADD, REQ_DATA, CLR_START,
    output REQ_READY, CLR_BUSY, WEN, WADD, DATAIN
  );

endinterface

// File: rtl/regfile_rr_pick.sv
// Combinational rotate-priority selector: first valid requester at or after ptr,
// wrapping modulo NumReq.
module regfile_rr_pick
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int unsigned NumReq   = DefNumReq,
  parameter int unsigned PtrWidth = ptr_width(NumReq)
) (
  input  logic [NumReq-1:0]   valid,
  input  logic [PtrWidth-1:0] ptr,
  output logic [NumReq-1:0]   gnt,
  output logic [PtrWidth-1:0] gnt_idx,
  output logic                gnt_any
);

  // Outer loop is priority order from ptr; inner loop maps it onto a fixed index
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < int'(NumReq); k++) begin
      for (int c = 0; c < int'(NumReq); c++) begin
        if (!gnt_any && valid[c] && (c == ((int'(ptr) + k) % int'(NumReq)))) begin
          gnt[c]  = 1'b1;
          gnt_idx = PtrWidth'(c);
          gnt_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: round-robin writeback arbitration and a
// sequenced software clear that zeroes every register through the write port.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned AddWidth  = DefAddWidth,
  parameter int unsigned NumReq    = DefNumReq
) (
  input logic               CLK,
  input logic               RESET_N,
  regfile_wb_ctrl_if.slave  bus
);

  localparam int unsigned PtrWidth = ptr_width(NumReq);
  localparam int unsigned CntWidth = AddWidth + 1;

  state_e                state_q, state_d;
  logic [PtrWidth-1:0]   ptr_q, ptr_d;
  logic [CntWidth-1:0]   clr_cnt_q, clr_cnt_d;
  logic                  wen_q, wen_d;
  logic [AddWidth-1:0]   wadd_q, wadd_d;
  logic [DataWidth-1:0]  data_q, data_d;

  logic [NumReq-1:0]     gnt;
  logic [PtrWidth-1:0]   gnt_idx;
  logic                  gnt_any;
  logic                  arb_open;
  logic                  xfer;
  logic                  clr_busy;
  logic [NumReq-1:0]     ready;
  logic [AddWidth-1:0]   sel_wadd;
  logic [DataWidth-1:0]  sel_data;

  regfile_rr_pick #(
    .NumReq   (NumReq),
    .PtrWidth (PtrWidth)
  ) u_pick (
    .valid   (bus.REQ_VALID),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StArb;
    end else begin
      state_q <= state_d;
    end
  end

  // Clear ends once the counter's extra MSB shows every address has been issued
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StArb:   if (bus.CLR_START) state_d = StClear;
      StClear: if (clr_cnt_q[AddWidth]) state_d = StArb;
      default: state_d = StArb;
    endcase
  end

  // Grants are suppressed during reset, during the clear and on the CLR_START cycle
  always_comb begin
    arb_open = 1'b0;
    clr_busy = 1'b0;
    unique case (state_q)
      StArb:   arb_open = RESET_N & ~bus.CLR_START;
      StClear: clr_busy = 1'b1;
      default: ;
    endcase
    ready = arb_open ? gnt : '0;
    xfer  = arb_open & gnt_any;
  end

  always_comb begin
    sel_wadd = '0;
    sel_data = '0;
    for (int k = 0; k < int'(NumReq); k++) begin
      if (gnt[k]) begin
        sel_wadd |= bus.REQ_WADD[k*AddWidth +: AddWidth];
        sel_data |= bus.REQ_DATA[k*DataWidth +: DataWidth];
      end
    end
  end

  // Address 0 is issued on the CLR_START edge so the clear occupies exactly
  // 2^AddWidth busy cycles; the terminal cycle issues nothing.
  always_comb begin
    ptr_d     = ptr_q;
    clr_cnt_d = clr_cnt_q;
    wen_d     = 1'b0;
    wadd_d    = wadd_q;
    data_d    = data_q;
    if (state_q == StClear) begin
      if (clr_cnt_q[AddWidth]) begin
        clr_cnt_d = '0;
      end else begin
        wen_d     = 1'b1;
        wadd_d    = clr_cnt_q[AddWidth-1:0];
        data_d    = '0;
        clr_cnt_d = clr_cnt_q + CntWidth'(1);
      end
    end else if (bus.CLR_START) begin
      wen_d     = 1'b1;
      wadd_d    = '0;
      data_d    = '0;
      clr_cnt_d = CntWidth'(1);
    end else if (xfer) begin
      wen_d  = 1'b1;
      wadd_d = sel_wadd;
      data_d = sel_data;
      ptr_d  = (gnt_idx == PtrWidth'(NumReq - 1)) ? '0 : gnt_idx + PtrWidth'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr_q     <= '0;
      clr_cnt_q <= '0;
      wen_q     <= 1'b0;
      wadd_q    <= '0;
      data_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      clr_cnt_q <= clr_cnt_d;
      wen_q     <= wen_d;
      wadd_q    <= wadd_d;
      data_q    <= data_d;
    end
  end

  assign bus.REQ_READY = ready;
  assign bus.CLR_BUSY  = clr_busy;
  assign bus.WEN       = wen_q;
  assign bus.WADD      = wadd_q;
  assign bus.DATAIN    = data_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_regfile_wb_ctrl;
  import regfile_wb_ctrl_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int NR    = 3;
  localparam int DEPTH = 1 << AW;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  regfile_wb_ctrl_if #(.DataWidth(DW), .AddWidth(AW), .NumReq(NR)) bus ();

  regfile_wb_ctrl #(.DataWidth(DW), .AddWidth(AW), .NumReq(NR)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  int n_cmp;
  int n_err;

  // Reference model: expected write-port outputs for the current cycle
  int             m_ptr;
  bit             m_busy;
  int             m_clrq[$];
  logic           m_wen;
  logic [AW-1:0]  m_wadd;
  logic [DW-1:0]  m_data;
  int             m_grant;

  function automatic int pick(logic [NR-1:0] v, int ptr);
    for (int k = 0; k < NR; k++) begin
      int c = (ptr + k) % NR;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic int exp_winner();
    if (m_busy || bus.CLR_START) return -1;
    return pick(bus.REQ_VALID, m_ptr);
  endfunction

  function automatic logic [AW-1:0] get_wadd(int k);
    logic [AW-1:0] r = '0;
    for (int i = 0; i < NR; i++) if (i == k) r = bus.REQ_WADD[i*AW +: AW];
    return r;
  endfunction

  function automatic logic [DW-1:0] get_data(int k);
    logic [DW-1:0] r = '0;
    for (int i = 0; i < NR; i++) if (i == k) r = bus.REQ_DATA[i*DW +: DW];
    return r;
  endfunction

  task automatic set_req(int k, logic [AW-1:0] a, logic [DW-1:0] d);
    for (int i = 0; i < NR; i++) begin
      if (i == k) begin
        bus.REQ_WADD[i*AW +: AW] = a;
        bus.REQ_DATA[i*DW +: DW] = d;
        bus.REQ_VALID[i]         = 1'b1;
      end
    end
  endtask

  task automatic drop_req(int k);
    for (int i = 0; i < NR; i++) if (i == k) bus.REQ_VALID[i] = 1'b0;
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_busy  = 0;
    m_clrq.delete();
    m_wen   = 1'b0;
    m_wadd  = '0;
    m_data  = '0;
    m_grant = -1;
  endtask

  // Advance one clock; the model consumes the inputs present at the edge
  task automatic tick();
    int g;
    @(posedge CLK);
    g       = exp_winner();
    m_grant = g;
    if (m_busy) begin
      if (m_clrq.size() > 0) begin
        m_wen  = 1'b1;
        m_wadd = AW'(m_clrq.pop_front());
        m_data = '0;
      end else begin
        m_busy = 0;
        m_wen  = 1'b0;
      end
    end else if (bus.CLR_START) begin
      m_clrq.delete();
      for (int a = 1; a < DEPTH; a++) m_clrq.push_back(a);
      m_busy = 1;
      m_wen  = 1'b1;
      m_wadd = '0;
      m_data = '0;
    end else if (g >= 0) begin
      m_wen  = 1'b1;
      m_wadd = get_wadd(g);
      m_data = get_data(g);
      m_ptr  = (g + 1) % NR;
    end else begin
      m_wen = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    RESET_N       = 1'b0;
    bus.REQ_VALID = '0;
    bus.REQ_WADD  = '0;
    bus.REQ_DATA  = '0;
    bus.CLR_START = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    RESET_N       = 1'b0;
    bus.REQ_VALID = '1;
    bus.REQ_WADD  = '1;
    bus.REQ_DATA  = '1;
    bus.CLR_START = 1'b0;
    #3;
    n_cmp++; if (bus.REQ_READY !== 3'b000) begin n_err++; $display("FAIL reset_ready: got %b expected 000", bus.REQ_READY); end
    n_cmp++; if (bus.WEN !== 1'b0) begin n_err++; $display("FAIL reset_wen: got %b expected 0", bus.WEN); end
    n_cmp++; if (bus.WADD !== 3'd0) begin n_err++; $display("FAIL reset_wadd: got %0h expected 0", bus.WADD); end
    n_cmp++; if (bus.DATAIN !== 16'h0) begin n_err++; $display("FAIL reset_datain: got %0h expected 0", bus.DATAIN); end
    n_cmp++; if (bus.CLR_BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.CLR_BUSY); end
    @(posedge CLK); #4;
    n_cmp++; if (bus.WEN !== 1'b0 || bus.REQ_READY !== 3'b000) begin
      n_err++; $display("FAIL reset_held: wen %b ready %b expected 0 000", bus.WEN, bus.REQ_READY);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_req(1, 3'd5, 16'hBEEF);
    #4;
    n_cmp++; if (bus.REQ_READY !== 3'b010) begin n_err++; $display("FAIL single_ready: got %b expected 010", bus.REQ_READY); end
    tick(); drop_req(1); #4;
    n_cmp++; if (bus.WEN !== 1'b1) begin n_err++; $display("FAIL single_wen: got %b expected 1", bus.WEN); end
    n_cmp++; if (bus.WADD !== 3'd5) begin n_err++; $display("FAIL single_wadd: got %0h expected 5", bus.WADD); end
    n_cmp++; if (bus.DATAIN !== 16'hBEEF) begin n_err++; $display("FAIL single_datain: got %0h expected beef", bus.DATAIN); end
    tick(); #4;
    n_cmp++; if (bus.WEN !== 1'b0) begin n_err++; $display("FAIL single_wen_drop: got %b expected 0", bus.WEN); end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] want;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    do_reset();
    for (int k = 0; k < NR; k++) set_req(k, AW'($urandom), DW'($urandom));
    pa = '0; pd = '0;
    for (int i = 0; i < 2 * NR; i++) begin
      #4;
      want = '0; want[i % NR] = 1'b1;
      n_cmp++; if (bus.REQ_READY !== want) begin n_err++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, bus.REQ_READY, want); end
      n_cmp++; if (bus.WEN !== (i > 0)) begin n_err++; $display("FAIL rr_wen[%0d]: got %b expected %b", i, bus.WEN, (i > 0)); end
      if (i > 0) begin
        n_cmp++; if (bus.WADD !== pa || bus.DATAIN !== pd) begin
          n_err++; $display("FAIL rr_write[%0d]: got %0h/%0h expected %0h/%0h", i, bus.WADD, bus.DATAIN, pa, pd);
        end
      end
      pa = get_wadd(i % NR);
      pd = get_data(i % NR);
      tick();
      set_req(i % NR, AW'($urandom), DW'($urandom));
    end
    #4;
    n_cmp++; if (bus.WEN !== 1'b1 || bus.WADD !== pa || bus.DATAIN !== pd) begin
      n_err++; $display("FAIL rr_last_write: got %b %0h/%0h expected 1 %0h/%0h", bus.WEN, bus.WADD, bus.DATAIN, pa, pd);
    end
  endtask

  task automatic test_clear();
    do_reset();
    set_req(0, 3'd3, 16'h1234);
    bus.CLR_START = 1'b1;
    #4;
    n_cmp++; if (bus.REQ_READY !== 3'b000) begin n_err++; $display("FAIL clr_start_ready: got %b expected 000", bus.REQ_READY); end
    tick(); bus.CLR_START = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.CLR_START = (k == 3);
      #4;
      n_cmp++; if (bus.WEN !== 1'b1 || bus.WADD !== AW'(k) || bus.DATAIN !== 16'h0) begin
        n_err++; $display("FAIL clr_write[%0d]: got %b %0h/%0h expected 1 %0h/0", k, bus.WEN, bus.WADD, bus.DATAIN, k);
      end
      n_cmp++; if (bus.CLR_BUSY !== 1'b1 || bus.REQ_READY !== 3'b000) begin
        n_err++; $display("FAIL clr_busy[%0d]: got busy %b ready %b expected 1 000", k, bus.CLR_BUSY, bus.REQ_READY);
      end
      tick();
    end
    bus.CLR_START = 1'b0;
    #4;
    n_cmp++; if (bus.REQ_READY !== 3'b001 || bus.CLR_BUSY !== 1'b0 || bus.WEN !== 1'b0) begin
      n_err++; $display("FAIL clr_after: got ready %b busy %b wen %b expected 001 0 0", bus.REQ_READY, bus.CLR_BUSY, bus.WEN);
    end
    tick(); drop_req(0); #4;
    n_cmp++; if (bus.WEN !== 1'b1 || bus.WADD !== 3'd3 || bus.DATAIN !== 16'h1234) begin
      n_err++; $display("FAIL clr_pending_write: got %b %0h/%0h expected 1 3/1234", bus.WEN, bus.WADD, bus.DATAIN);
    end
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    set_req(0, 3'd2, 16'h1111);
    tick(); drop_req(0);
    bus.CLR_START = 1'b1;
    tick(); bus.CLR_START = 1'b0;
    repeat (3) tick();
    #1; RESET_N = 1'b0; #1;
    n_cmp++; if (bus.WEN !== 1'b0 || bus.CLR_BUSY !== 1'b0) begin
      n_err++; $display("FAIL midclr_reset: got wen %b busy %b expected 0 0", bus.WEN, bus.CLR_BUSY);
    end
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    model_reset();
    set_req(0, 3'd4, 16'hA0A0);
    set_req(1, 3'd6, 16'hB0B0);
    set_req(2, 3'd7, 16'hC0C0);
    #4;
    n_cmp++; if (bus.REQ_READY !== 3'b001 || bus.CLR_BUSY !== 1'b0) begin
      n_err++; $display("FAIL midclr_regrant: got ready %b busy %b expected 001 0", bus.REQ_READY, bus.CLR_BUSY);
    end
    tick(); drop_req(0); #4;
    n_cmp++; if (bus.WEN !== 1'b1 || bus.WADD !== 3'd4 || bus.DATAIN !== 16'hA0A0) begin
      n_err++; $display("FAIL midclr_write: got %b %0h/%0h expected 1 4/a0a0", bus.WEN, bus.WADD, bus.DATAIN);
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_req(2, 3'd6, 16'hCAFE);
    set_req(0, 3'd1, 16'h0101);
    set_req(1, 3'd2, 16'h0202);
    #4;
    n_cmp++; if (bus.REQ_READY !== 3'b001) begin n_err++; $display("FAIL stall_g0: got %b expected 001", bus.REQ_READY); end
    tick(); drop_req(0); #4;
    n_cmp++; if (bus.REQ_READY !== 3'b010) begin n_err++; $display("FAIL stall_g1: got %b expected 010", bus.REQ_READY); end
    tick(); drop_req(1); #4;
    n_cmp++; if (bus.REQ_READY !== 3'b100) begin n_err++; $display("FAIL stall_g2: got %b expected 100", bus.REQ_READY); end
    tick(); drop_req(2); #4;
    n_cmp++; if (bus.WEN !== 1'b1 || bus.WADD !== 3'd6 || bus.DATAIN !== 16'hCAFE) begin
      n_err++; $display("FAIL stall_write: got %b %0h/%0h expected 1 6/cafe", bus.WEN, bus.WADD, bus.DATAIN);
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] want;
    int            g;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < NR; k++) begin
        if (!bus.REQ_VALID[k] && ($urandom_range(0, 2) != 0)) set_req(k, AW'($urandom), DW'($urandom));
      end
      bus.CLR_START = ($urandom_range(0, 39) == 0);
      #4;
      g = exp_winner();
      want = '0;
      if (g >= 0) want[g] = 1'b1;
      n_cmp++; if (bus.REQ_READY !== want) begin n_err++; $display("FAIL rand_ready@%0d: got %b expected %b", cyc, bus.REQ_READY, want); end
      n_cmp++; if (bus.WEN !== m_wen) begin n_err++; $display("FAIL rand_wen@%0d: got %b expected %b", cyc, bus.WEN, m_wen); end
      n_cmp++; if (bus.WADD !== m_wadd) begin n_err++; $display("FAIL rand_wadd@%0d: got %0h expected %0h", cyc, bus.WADD, m_wadd); end
      n_cmp++; if (bus.DATAIN !== m_data) begin n_err++; $display("FAIL rand_datain@%0d: got %0h expected %0h", cyc, bus.DATAIN, m_data); end
      n_cmp++; if (bus.CLR_BUSY !== m_busy) begin n_err++; $display("FAIL rand_busy@%0d: got %b expected %b", cyc, bus.CLR_BUSY, m_busy); end
      tick();
      if (m_grant >= 0) drop_req(m_grant);
      bus.CLR_START = 1'b0;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_clear();
    test_reset_mid_clear();
    test_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
